// File: rtl/mix_columns_seq_pkg.sv
// Shared definitions for the sequential AES MixColumns engine.
//   AES_POLY : low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   NB       : columns per AES state
//   STATE_W  : state width in bits
//   COL_W    : column width in bits
//   state_e  : controller state encoding
package mix_columns_seq_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;
  localparam int         NB       = 4;
  localparam int         STATE_W  = 128;
  localparam int         COL_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mix_columns_seq_mix_single_column.sv
// mix_single_column: combinational MixColumns of one 32-bit AES column.
//   col_i : input column, row 0 in [31:24] down to row 3 in [7:0]
//   col_o : mixed column, same byte layout
module mix_single_column
  import mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  // Multiply by x in GF(2^8): shift, then fold the overflow bit back in.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign {a0, a1, a2, a3} = col_i;

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3*a is expanded as 2*a ^ a.
  assign col_o[31:24] = x0        ^ (x1 ^ a1) ^ a2        ^ a3;
  assign col_o[23:16] = a0        ^ x1        ^ (x2 ^ a2) ^ a3;
  assign col_o[15:8]  = a0        ^ a1        ^ x2        ^ (x3 ^ a3);
  assign col_o[7:0]   = (x0 ^ a0) ^ a1        ^ a2        ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns, COLS_PER_CYCLE columns per cycle.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : input handshake; in_data sampled only on accept
//   in_data           : 128-bit state, column c at [127-32c -: 32]
//   out_valid/out_ready : output handshake; result held until accepted
//   out_data          : MixColumns(in_data), zero when no result is held
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // col_cnt is 2 bits, so stepping by 4 is a step of 0 and the single
  // group is both first and last.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % NB);
  localparam logic [1:0] LAST_CNT = 2'(NB - COLS_PER_CYCLE);
  localparam logic [1:0] TOP_COL  = 2'(NB - 1);

  state_e                     state_q, state_d;
  logic [1:0]                 col_cnt_q;
  // Packed view of the state: column c lives at work_q[NB-1-c], which
  // lines up with the FIPS byte order of in_data.
  logic [NB-1:0][COL_W-1:0]   work_q, work_d;

  logic [COLS_PER_CYCLE-1:0][1:0]       lane_idx;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0] lane_in, lane_out;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign lane_idx[g] = col_cnt_q + 2'(g);
    assign lane_in[g]  = work_q[TOP_COL - lane_idx[g]];
    mix_single_column u_mix (
      .col_i (lane_in[g]),
      .col_o (lane_out[g])
    );
  end

  always_comb begin
    work_d = work_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++)
      work_d[TOP_COL - lane_idx[i]] = lane_out[i];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)              state_d = BUSY;
      BUSY:    if (col_cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = (state_q == DONE) ? work_q : '0;
  end

  // Working register and column counter
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q    <= '0;
      col_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          work_q    <= in_data;
          col_cnt_q <= '0;
        end
        BUSY: begin
          work_q    <= work_d;
          col_cnt_q <= col_cnt_q + CNT_STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: one instance per legal
// COLS_PER_CYCLE, directed vectors plus random vectors against a
// polynomial-arithmetic MixColumns model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

  // GF(2^8) product: carry-less polynomial multiply, then long division
  // by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++)
      if (a[i]) p = p ^ (b << i);
    for (int i = 15; i >= 8; i--)
      if ((p >> i) & 1) p = p ^ ('h11b << (i - 8));
    return 8'(p);
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    int m [4][4] = '{'{2,3,1,1}, '{1,2,3,1}, '{1,1,2,3}, '{3,1,1,2}};
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], m[row][k]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Accept one vector on instance k and follow it through to the handshake.
  task automatic run_one(input int k, input logic [127:0] d, input logic [127:0] expv,
                         input int lat, input string tag);
    int n;
    out_ready[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 20) begin step(); n++; end
    check({tag, "_rdy"}, 128'(in_ready[k]), 128'(1));
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    step();
    in_valid[k] = 1'b0;
    in_data[k]  = rnd128();          // result must not depend on post-accept data
    check({tag, "_busy"}, 128'(in_ready[k]), 128'(0));
    n = 0;
    while (!out_valid[k] && n < 20) begin step(); n++; end
    check({tag, "_lat"},  128'(n), 128'(lat));
    check({tag, "_data"}, out_data[k], expv);
    step();
    check({tag, "_vdrop"}, 128'(out_valid[k]), 128'(0));
    check({tag, "_ridle"}, 128'(in_ready[k]), 128'(1));
  endtask

  initial begin
    logic [127:0] va, vb, vexp;
    logic         seen;
    int           t1, t2;
    logic [127:0] res [$];
    logic         rdy, v, ov;
    logic [127:0] od;
    int           lats [3] = '{4, 2, 1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
    end
    step(); step();
    rst = 1'b0;

    // Reset state
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready",  128'(in_ready[k]),  128'(1));
      check("rst_out_valid", 128'(out_valid[k]), 128'(0));
      check("rst_out_data",  out_data[k],        128'(0));
    end

    // Known vector, one column per cycle
    run_one(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
               128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4, "t1");

    // FIPS-197 round 1 on every width
    for (int k = 0; k < 3; k++)
      run_one(k, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                 128'h046681e5_e0cb199a_48f8d37a_2806264c, lats[k], "fips");

    // Bytes with MSB set exercise the reduction
    for (int k = 0; k < 3; k++)
      run_one(k, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6,
                 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, lats[k], "msb");

    // Random vectors against the model
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 3; k++) begin
        va = rnd128();
        run_one(k, va, mix_ref(va), lats[k], "rand");
      end

    // Backpressure: result held while out_ready is low
    va = rnd128(); vb = rnd128(); vexp = mix_ref(va);
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = va;
    step();
    t1 = 0;
    while (!out_valid[0] && t1 < 20) begin
      in_valid[0] = 1'($urandom); in_data[0] = rnd128();
      step(); t1++;
    end
    check("bp_lat", 128'(t1), 128'(4));
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'($urandom); in_data[0] = rnd128();
      step();
      check("bp_hold_data",  out_data[0],        vexp);
      check("bp_hold_valid", 128'(out_valid[0]), 128'(1));
      check("bp_hold_rdy",   128'(in_ready[0]),  128'(0));
    end
    in_valid[0] = 1'b1; in_data[0] = vb; out_ready[0] = 1'b1;
    step();                                   // handshake edge
    check("bp_after_hs_rdy", 128'(in_ready[0]), 128'(1));
    step();                                   // second vector accepted here
    in_valid[0] = 1'b0;
    check("bp_b_accepted", 128'(in_ready[0]), 128'(0));
    t1 = 0;
    while (!out_valid[0] && t1 < 20) begin step(); t1++; end
    check("bp_b_data", out_data[0], mix_ref(vb));
    step();

    // Reset during the second BUSY cycle
    va = rnd128();
    in_valid[0] = 1'b1; in_data[0] = va;
    step();                                   // accept
    in_valid[0] = 1'b0;
    step();                                   // first BUSY edge
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_rdy",   128'(in_ready[0]),  128'(1));
    check("mid_rst_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_data",  out_data[0],        128'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid[0]) seen = 1'b1;
    end
    check("mid_rst_no_out", 128'(seen), 128'(0));
    va = rnd128();
    run_one(0, va, mix_ref(va), 4, "post_rst");

    // Back-to-back with in_valid held high
    va = rnd128(); vb = rnd128();
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = va;
    t1 = -1; t2 = -1;
    for (int t = 1; t <= 30; t++) begin
      rdy = in_ready[0]; v = in_valid[0]; ov = out_valid[0]; od = out_data[0];
      step();
      if (ov) res.push_back(od);
      if (rdy && v) begin
        if (t1 < 0) begin t1 = t; in_data[0] = vb; end
        else begin t2 = t; in_valid[0] = 1'b0; end
      end
    end
    check("b2b_spacing", 128'(t2 - t1), 128'(6));
    check("b2b_count",   128'(res.size()), 128'(2));
    check("b2b_r0", (res.size() > 0) ? res[0] : 'x, mix_ref(va));
    check("b2b_r1", (res.size() > 1) ? res[1] : 'x, mix_ref(vb));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
